black_box_passthrough2: RTL and testbench
=========================================

# black_box_passthrough2

Combinational pass-through with registered side-band activity monitors. `out` mirrors `in` in the same cycle, with no clock or reset dependency, so a consumer sampling `out` sees exactly what was driven on `in`. The monitors let a test harness or debug logic check what crossed the boundary: a delayed copy, a toggle count, a high-cycle count and a sticky zero-seen flag. The block sits as a leaf wrapper at an integration boundary.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `in`/`out`.
- `CNT_W`, default 16: width of each activity counter.

Ports:
- `clock`  input  1  clock; all monitor state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset for the monitor state.
- `in`  input  WIDTH  data input.
- `out`  output  WIDTH  data output, `out = in` combinationally.
- `clr`  input  1  synchronous clear of counters and flag.
- `in_q`  output  WIDTH  `in` registered by one cycle.
- `toggle_count`  output  CNT_W  number of cycles where `in` differed from the previous cycle's `in`; saturating.
- `high_count`  output  CNT_W  number of cycles where `in` is all-ones; saturating.
- `seen_zero`  output  1  sticky; set once `in` is sampled all-zero.

## Operation
**Data path**
- `out = in` at all times, including during reset and during `clr`.
- No register, gate or other logic sits in the data path.

**Reset** (`reset == 0` at a rising edge)
- `in_q <= 0`, `toggle_count <= 0`, `high_count <= 0`, `seen_zero <= 0`.
- A separate `first` flag is set to 1 in the same edge.

**Normal edge** (`reset == 1`)
- `in_q <= in`.
- `first <= 0`.
- Toggle counting: if `first == 0` and `in != in_q`, increment `toggle_count` unless it is all-ones. The first cycle after reset never counts a toggle.
- High counting: if `in` is all-ones, increment `high_count` unless it is all-ones.
- Zero flag: if `in == 0`, `seen_zero <= 1`.

**Clear** (`clr == 1` with `reset == 1`)
- Counters go to 0 and `seen_zero` goes to 0.
- `in_q` still loads `in`.
- The current cycle's `in` is not counted.

**Precedence and arithmetic**
- `reset` overrides `clr`.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- `WIDTH == 1`: all-ones means `in == 1`.

## Timing
- `in` → `out`: combinational, zero-cycle latency.
- `in` → `in_q`: one cycle.
- Counter and flag outputs reflect events up to and including the previous edge.
- Every output except `out` is registered.
- Reset mid-operation: monitor state clears on the next edge; `out` keeps following `in` with no interruption.
- No handshake; every cycle is a valid sample.

## Test plan
- **Pass-through:** `WIDTH=1`, `in = 1` constant, `reset` released.
  - Every cycle `out == 1`, including reset cycles.
  - After N edges, `high_count == N` and `toggle_count == 0`.
- **Toggle counting:** drive `in` = 0,1,0,1,1 on consecutive post-reset edges.
  - Requires `toggle_count == 3`, `high_count == 3`, `seen_zero == 1`.
- **Delay:** `WIDTH=8`, drive `in` = 0xA5 then 0x3C.
  - `out` changes in the same cycle as `in`.
  - `in_q == 0xA5` one edge after 0xA5 was applied.
- **Saturation:** `CNT_W=4`, `in = 1` for 20 edges.
  - `high_count` holds at 15 and does not wrap to 0.
- **Clear vs reset:**
  - `clr = 1` for one edge → counters 0 and `seen_zero` 0, while `in_q` still updates.
  - `reset = 0` and `clr = 1` together → `in_q == 0`.
- **Mid-run reset:** assert `reset = 0` for one edge while `in` is toggling.
  - Monitor state is all-zero after that edge.
  - The first post-reset cycle adds no toggle.
  - `out` tracks `in` throughout.

Source files
------------

// File: rtl/black_box_passthrough2.sv
// rtl/black_box_passthrough2.sv - combinational pass-through with registered activity monitors
module black_box_passthrough2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             clr,
  output logic [WIDTH-1:0] in_q,
  output logic [CNT_W-1:0] toggle_count,
  output logic [CNT_W-1:0] high_count,
  output logic             seen_zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Suppresses the toggle comparison against the reset value of in_q.
  logic first;

  logic toggle_hit;
  logic high_hit;
  logic zero_hit;

  // Data path is a plain wire: no clock, reset or clear dependency.
  assign out = in;

  // Per-cycle event decode against the previous sample.
  always_comb begin
    toggle_hit = 1'b0;
    high_hit   = 1'b0;
    zero_hit   = 1'b0;
    if (!first && (in != in_q)) begin
      toggle_hit = 1'b1;
    end
    if (in == ALL_ONES) begin
      high_hit = 1'b1;
    end
    if (in == ALL_ZERO) begin
      zero_hit = 1'b1;
    end
  end

  // Delayed copy and first-cycle marker; clear does not stop in_q loading.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_q  <= '0;
      first <= 1'b1;
    end else begin
      in_q  <= in;
      first <= 1'b0;
    end
  end

  // Saturating toggle counter.
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      toggle_count <= '0;
    end else if (toggle_hit && (toggle_count != CNT_MAX)) begin
      toggle_count <= toggle_count + CNT_ONE;
    end
  end

  // Saturating all-ones cycle counter.
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      high_count <= '0;
    end else if (high_hit && (high_count != CNT_MAX)) begin
      high_count <= high_count + CNT_ONE;
    end
  end

  // Sticky all-zero flag.
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      seen_zero <= 1'b0;
    end else if (zero_hit) begin
      seen_zero <= 1'b1;
    end
  end

endmodule

// File: tb/tb_black_box_passthrough2.sv
// tb/tb_black_box_passthrough2.sv - scoreboard bench for black_box_passthrough2
module tb_black_box_passthrough2;

  logic        clock;
  logic        reset;
  logic        clr;
  logic [0:0]  a_in;
  logic [0:0]  a_out;
  logic [0:0]  a_inq;
  logic [3:0]  a_tog;
  logic [3:0]  a_high;
  logic        a_sz;
  logic [7:0]  b_in;
  logic [7:0]  b_out;
  logic [7:0]  b_inq;
  logic [15:0] b_tog;
  logic [15:0] b_high;
  logic        b_sz;

  typedef struct packed {
    logic [0:0]  a_inq;
    logic [3:0]  a_tog;
    logic [3:0]  a_high;
    logic        a_sz;
    logic [7:0]  b_inq;
    logic [15:0] b_tog;
    logic [15:0] b_high;
    logic        b_sz;
  } st_t;

  st_t q[$];
  st_t exp_s;
  st_t got_s;
  int  checks;
  int  failures;

  logic [0:0]  ma_inq;
  logic [3:0]  ma_tog;
  logic [3:0]  ma_high;
  logic        ma_sz;
  logic        ma_first;
  logic [7:0]  mb_inq;
  logic [15:0] mb_tog;
  logic [15:0] mb_high;
  logic        mb_sz;
  logic        mb_first;

  black_box_passthrough2 #(.WIDTH(1), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .in(a_in), .out(a_out), .clr(clr),
    .in_q(a_inq), .toggle_count(a_tog), .high_count(a_high), .seen_zero(a_sz)
  );

  black_box_passthrough2 #(.WIDTH(8), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .in(b_in), .out(b_out), .clr(clr),
    .in_q(b_inq), .toggle_count(b_tog), .high_count(b_high), .seen_zero(b_sz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive inputs at the falling edge and push the predicted post-edge state.
  task automatic drive(input logic [0:0] ai, input logic [7:0] bi, input logic rst, input logic cl);
    @(negedge clock);
    a_in  = ai;
    b_in  = bi;
    reset = rst;
    clr   = cl;
    if (!rst) begin
      ma_inq = '0; ma_tog = '0; ma_high = '0; ma_sz = 1'b0; ma_first = 1'b1;
      mb_inq = '0; mb_tog = '0; mb_high = '0; mb_sz = 1'b0; mb_first = 1'b1;
    end else if (cl) begin
      ma_inq = ai; ma_tog = '0; ma_high = '0; ma_sz = 1'b0; ma_first = 1'b0;
      mb_inq = bi; mb_tog = '0; mb_high = '0; mb_sz = 1'b0; mb_first = 1'b0;
    end else begin
      if (!ma_first && ai != ma_inq && ma_tog != 4'hF) ma_tog = ma_tog + 4'd1;
      if (ai == 1'b1 && ma_high != 4'hF) ma_high = ma_high + 4'd1;
      if (ai == 1'b0) ma_sz = 1'b1;
      ma_inq = ai; ma_first = 1'b0;
      if (!mb_first && bi != mb_inq && mb_tog != 16'hFFFF) mb_tog = mb_tog + 16'd1;
      if (bi == 8'hFF && mb_high != 16'hFFFF) mb_high = mb_high + 16'd1;
      if (bi == 8'h00) mb_sz = 1'b1;
      mb_inq = bi; mb_first = 1'b0;
    end
    q.push_back('{ma_inq, ma_tog, ma_high, ma_sz, mb_inq, mb_tog, mb_high, mb_sz});
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    got_s = '{a_inq, a_tog, a_high, a_sz, b_inq, b_tog, b_high, b_sz};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      checks++;
      if (a_out !== 1'b1 || b_out !== 8'h00) begin
        failures++;
        $display("FAIL reset_out got a=%h b=%h want a=1 b=00", a_out, b_out);
      end
      tick();
      exp_s = q.pop_front();
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL reset_state got %h want %h", got_s, exp_s);
      end
    end
    checks++;
    if ({a_inq, a_tog, a_high, a_sz} !== 10'd0) begin
      failures++;
      $display("FAIL reset_zero got %h want 000", {a_inq, a_tog, a_high, a_sz});
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h11, 1'b1, 1'b0);
      checks++;
      if (a_out !== 1'b1) begin
        failures++;
        $display("FAIL pass_out got %h want 1", a_out);
      end
      tick();
      exp_s = q.pop_front();
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL pass_state got %h want %h", got_s, exp_s);
      end
    end
    checks++;
    if (a_high !== 4'd5 || a_tog !== 4'd0) begin
      failures++;
      $display("FAIL pass_counts got high=%0d tog=%0d want high=5 tog=0", a_high, a_tog);
    end
  endtask

  task automatic test_toggle();
    logic [0:0] seq [5];
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    void'(q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 8'h00, 1'b1, 1'b0);
      tick();
      exp_s = q.pop_front();
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL toggle_state got %h want %h", got_s, exp_s);
      end
    end
    checks++;
    if (a_tog !== 4'd3 || a_high !== 4'd3 || a_sz !== 1'b1) begin
      failures++;
      $display("FAIL toggle_counts got tog=%0d high=%0d sz=%0d want 3 3 1", a_tog, a_high, a_sz);
    end
  endtask

  task automatic test_delay();
    drive(1'b0, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (b_out !== 8'hA5) begin
      failures++;
      $display("FAIL delay_out0 got %h want a5", b_out);
    end
    tick();
    void'(q.pop_front());
    checks++;
    if (b_inq !== 8'hA5) begin
      failures++;
      $display("FAIL delay_inq got %h want a5", b_inq);
    end
    drive(1'b0, 8'h3C, 1'b1, 1'b0);
    checks++;
    if (b_out !== 8'h3C || b_inq !== 8'hA5) begin
      failures++;
      $display("FAIL delay_out1 got out=%h inq=%h want 3c a5", b_out, b_inq);
    end
    tick();
    exp_s = q.pop_front();
    checks++;
    if (got_s !== exp_s) begin
      failures++;
      $display("FAIL delay_state got %h want %h", got_s, exp_s);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    void'(q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 1'b0);
      tick();
      exp_s = q.pop_front();
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL sat_state got %h want %h", got_s, exp_s);
      end
    end
    checks++;
    if (a_high !== 4'd15 || b_high !== 16'd20) begin
      failures++;
      $display("FAIL sat_high got a=%0d b=%0d want 15 20", a_high, b_high);
    end
  endtask

  task automatic test_clear_reset();
    drive(1'b0, 8'h5A, 1'b1, 1'b1);
    tick();
    exp_s = q.pop_front();
    checks++;
    if (a_tog !== 4'd0 || a_high !== 4'd0 || a_sz !== 1'b0 || b_sz !== 1'b0 || b_inq !== 8'h5A) begin
      failures++;
      $display("FAIL clear got tog=%0d high=%0d sz=%0d bsz=%0d binq=%h want 0 0 0 0 5a",
               a_tog, a_high, a_sz, b_sz, b_inq);
    end
    checks++;
    if (got_s !== exp_s) begin
      failures++;
      $display("FAIL clear_state got %h want %h", got_s, exp_s);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    tick();
    exp_s = q.pop_front();
    checks++;
    if (b_inq !== 8'h00 || a_inq !== 1'b0 || got_s !== exp_s) begin
      failures++;
      $display("FAIL reset_over_clr got %h want %h", got_s, exp_s);
    end
  endtask

  task automatic test_midrun_reset();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    void'(q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'(i), 8'(i * 37 + 1), 1'b1, 1'b0);
      tick();
      void'(q.pop_front());
    end
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    checks++;
    if (b_out !== 8'h81) begin
      failures++;
      $display("FAIL mid_out got %h want 81", b_out);
    end
    tick();
    exp_s = q.pop_front();
    checks++;
    if (got_s !== 90'd0 || got_s !== exp_s) begin
      failures++;
      $display("FAIL mid_reset got %h want %h", got_s, exp_s);
    end
    drive(1'b0, 8'h7E, 1'b1, 1'b0);
    checks++;
    if (b_out !== 8'h7E || a_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_out2 got a=%h b=%h want 0 7e", a_out, b_out);
    end
    tick();
    exp_s = q.pop_front();
    checks++;
    if (a_tog !== 4'd0 || b_tog !== 16'd0 || got_s !== exp_s) begin
      failures++;
      $display("FAIL mid_first got %h want %h", got_s, exp_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bv;
    for (int i = 0; i < 40; i++) begin
      bv = 8'($urandom_range(0, 3));
      if (bv == 8'd3) bv = 8'hFF;
      drive(1'($urandom_range(0, 1)), bv, 1'b1, ($urandom_range(0, 9) == 0));
      checks++;
      if (a_out !== a_in || b_out !== b_in) begin
        failures++;
        $display("FAIL b2b_out got a=%h b=%h want a=%h b=%h", a_out, b_out, a_in, b_in);
      end
      tick();
      exp_s = q.pop_front();
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL b2b_state got %h want %h", got_s, exp_s);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clr      = 1'b0;
    a_in     = '0;
    b_in     = '0;
    test_reset();
    test_passthrough();
    test_toggle();
    test_delay();
    test_saturation();
    test_clear_reset();
    test_midrun_reset();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
